// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: raises pipeline stalls and bubbles for the hazards that
// forwarding cannot fix. These are a load feeding the next instruction, a load
// feeding the stage-2 branch comparator, and a multi-cycle mul/div in EX.
// The first stall cycle is decoded combinationally in IDLE. Any later stall
// cycles come from the FSM and its down-counter.
module hazard_stall_unit #(
  parameter int unsigned WE_BIT        = 11,
  parameter int unsigned MEMRD_BIT     = 5,
  parameter int unsigned MULDIV_BIT    = 12,
  parameter int unsigned MULDIV_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  Op1AddrFromIFID,
  input  logic [3:0]  Op2AddrFromIFID,
  input  logic        BranchInIFID,
  input  logic [3:0]  Op1AddrFromIDEX,
  input  logic [13:0] ControlSignalsFromIDEX,
  output logic        PCWrite,
  output logic        IFIDWrite,
  output logic        IDEXWrite,
  output logic        IDEXBubble,
  output logic        EXMEMBubble,
  output logic        StallActive,
  output logic [3:0]  StallCount
);

  localparam int unsigned CNT_W = 4;
  localparam logic MD_STALLS = (MULDIV_CYCLES > 1);
  // Registered MD_BUSY cycles that follow the combinational first stall cycle.
  localparam logic [CNT_W-1:0] MD_LOAD =
    (MULDIV_CYCLES > 1) ? CNT_W'(MULDIV_CYCLES - 2) : '0;
  localparam logic [CNT_W-1:0] BR_LOAD = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BR_STALL = 2'd1,
    MD_BUSY  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic wr, ld, md, use_hit, buse;
  logic md_stall, br_stall, lu_stall;
  logic ctrl_unused;

  // Hazard decode on the instruction pair currently in ID and EX.
  assign wr       = ~ControlSignalsFromIDEX[WE_BIT];
  assign ld       = wr & ControlSignalsFromIDEX[MEMRD_BIT];
  assign md       = ControlSignalsFromIDEX[MULDIV_BIT];
  assign use_hit  = (Op1AddrFromIDEX == Op1AddrFromIFID) |
                    (Op1AddrFromIDEX == Op2AddrFromIFID);
  assign buse     = BranchInIFID & ((Op1AddrFromIDEX == Op1AddrFromIFID) |
                                    (Op1AddrFromIDEX == 4'hF));
  assign md_stall = md & MD_STALLS;
  assign br_stall = ld & buse;
  assign lu_stall = ld & use_hit;

  // Only three control bits matter here; fold the word so nothing dangles.
  assign ctrl_unused = ^ControlSignalsFromIDEX;

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and counter. cnt_d is the number of stall cycles still to come.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (rst) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (md_stall) begin
            cnt_d   = MD_LOAD;
            state_d = (MD_LOAD == '0) ? IDLE : MD_BUSY;
          end else if (br_stall) begin
            cnt_d   = BR_LOAD;
            state_d = BR_STALL;
          end
        end
        BR_STALL, MD_BUSY: begin
          if (cnt_q <= CNT_W'(1)) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Pipeline controls. A mul/div holds ID/EX. A load hazard bubbles ID/EX.
  always_comb begin
    PCWrite     = 1'b1;
    IFIDWrite   = 1'b1;
    IDEXWrite   = 1'b1;
    IDEXBubble  = 1'b0;
    EXMEMBubble = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (md_stall) begin
            PCWrite     = 1'b0;
            IFIDWrite   = 1'b0;
            IDEXWrite   = 1'b0;
            EXMEMBubble = 1'b1;
          end else if (br_stall || lu_stall) begin
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
            IDEXBubble = 1'b1;
          end
        end
        BR_STALL: begin
          PCWrite    = 1'b0;
          IFIDWrite  = 1'b0;
          IDEXBubble = 1'b1;
        end
        MD_BUSY: begin
          PCWrite     = 1'b0;
          IFIDWrite   = 1'b0;
          IDEXWrite   = 1'b0;
          EXMEMBubble = 1'b1;
        end
        default: begin
          PCWrite = 1'b1;
        end
      endcase
    end
    StallActive = ~PCWrite;
  end

  assign StallCount = cnt_d;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Bench for hazard_stall_unit. A queue-based model predicts the stall cycles:
// each detected hazard queues its whole stall sequence at once.
module tb_hazard_stall_unit;

  localparam int unsigned MDC = 4;
  localparam logic [9:0] REL = {6'b111000, 4'd0};

  logic        clk;
  logic        rst;
  logic [3:0]  op1_ifid, op2_ifid, op1_idex;
  logic        br_ifid;
  logic [13:0] ctrl;
  logic        pc_w, ifid_w, idex_w, idex_b, exmem_b, stall_a;
  logic [3:0]  stall_cnt;

  int checks   = 0;
  int failures = 0;
  int q[$];
  logic [9:0] exp_v, obs_v;

  hazard_stall_unit #(
    .WE_BIT(11), .MEMRD_BIT(5), .MULDIV_BIT(12), .MULDIV_CYCLES(MDC)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .Op1AddrFromIFID        (op1_ifid),
    .Op2AddrFromIFID        (op2_ifid),
    .BranchInIFID           (br_ifid),
    .Op1AddrFromIDEX        (op1_idex),
    .ControlSignalsFromIDEX (ctrl),
    .PCWrite                (pc_w),
    .IFIDWrite              (ifid_w),
    .IDEXWrite              (idex_w),
    .IDEXBubble             (idex_b),
    .EXMEMBubble            (exmem_b),
    .StallActive            (stall_a),
    .StallCount             (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Build a control word: we_n is active-low write enable.
  function automatic logic [13:0] mkctrl(input logic we_n, input logic memrd,
                                         input logic muldiv);
    logic [13:0] c;
    c = '0;
    c[11] = we_n;
    c[5]  = memrd;
    c[12] = muldiv;
    return c;
  endfunction

  task automatic drive(input logic r, input logic [13:0] c, input logic [3:0] dst,
                       input logic [3:0] s1, input logic [3:0] s2, input logic b);
    rst = r; ctrl = c; op1_idex = dst; op1_ifid = s1; op2_ifid = s2; br_ifid = b;
  endtask

  // Model: an empty queue means no stall is pending. A new hazard queues all of
  // its stall cycles. StallCount is the number of cycles left after this one.
  task automatic model_step(output logic [9:0] e);
    logic wr, ld, md, use_h, buse;
    int kind;
    if (rst) begin
      q.delete();
      e = REL;
      return;
    end
    if (q.size() == 0) begin
      wr    = !ctrl[11];
      ld    = wr && ctrl[5];
      md    = ctrl[12];
      use_h = (op1_idex == op1_ifid) || (op1_idex == op2_ifid);
      buse  = br_ifid && ((op1_idex == op1_ifid) || (op1_idex == 4'hF));
      if (md && MDC > 1) repeat (MDC - 1) q.push_back(1);
      else if (ld && buse) repeat (2) q.push_back(0);
      else if (ld && use_h) q.push_back(0);
    end
    if (q.size() == 0) begin
      e = REL;
    end else begin
      kind = q.pop_front();
      e = kind ? {6'b000011, 4'(q.size())} : {6'b001101, 4'(q.size())};
    end
  endtask

  // Apply the driven inputs for one cycle and sample outputs on the falling edge.
  task automatic step();
    model_step(exp_v);
    @(negedge clk);
    obs_v = {pc_w, ifid_w, idex_w, idex_b, exmem_b, stall_a, stall_cnt};
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, mkctrl(1'b0, 1'b1, i[0]), 4'd3, 4'd3, 4'd3, 1'b1);
      step();
      checks++;
      if (obs_v !== REL) begin
        failures++;
        $display("FAIL reset cyc%0d got=%b exp=%b", i, obs_v, REL);
      end
    end
  endtask

  task automatic test_load_use();
    drive(1'b0, mkctrl(1'b0, 1'b1, 1'b0), 4'd3, 4'd7, 4'd3, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (obs_v !== exp_v) begin
        failures++;
        $display("FAIL load_use cyc%0d got=%b exp=%b", i, obs_v, exp_v);
      end
      drive(1'b0, '0, 4'd0, 4'd1, 4'd2, 1'b0);
    end
  endtask

  task automatic test_load_branch();
    drive(1'b0, mkctrl(1'b0, 1'b1, 1'b0), 4'hF, 4'd2, 4'd9, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (obs_v !== exp_v) begin
        failures++;
        $display("FAIL load_branch cyc%0d got=%b exp=%b", i, obs_v, exp_v);
      end
      drive(1'b0, '0, 4'd0, 4'd1, 4'd2, 1'b0);
    end
  endtask

  task automatic test_muldiv();
    drive(1'b0, mkctrl(1'b0, 1'b0, 1'b1), 4'd5, 4'd5, 4'd5, 1'b0);
    for (int i = 0; i < MDC; i++) begin
      step();
      checks++;
      if (obs_v !== exp_v) begin
        failures++;
        $display("FAIL muldiv cyc%0d got=%b exp=%b", i, obs_v, exp_v);
      end
      // Hazardous inputs during busy cycles must be ignored.
      drive(1'b0, mkctrl(1'b0, 1'b1, 1'b0), 4'd5, 4'd5, 4'd5, 1'b1);
    end
    drive(1'b0, '0, 4'd0, 4'd1, 4'd2, 1'b0);
    step();
  endtask

  task automatic test_no_stall();
    // Non-load writer, then a load that does not write.
    drive(1'b0, mkctrl(1'b0, 1'b0, 1'b0), 4'd3, 4'd3, 4'd3, 1'b1);
    step();
    checks++;
    if (obs_v !== REL) begin
      failures++;
      $display("FAIL alu_writer got=%b exp=%b", obs_v, REL);
    end
    drive(1'b0, mkctrl(1'b1, 1'b1, 1'b0), 4'd4, 4'd4, 4'd0, 1'b0);
    step();
    checks++;
    if (obs_v !== REL) begin
      failures++;
      $display("FAIL load_nowrite got=%b exp=%b", obs_v, REL);
    end
    // R0 compares like any register.
    drive(1'b0, mkctrl(1'b0, 1'b1, 1'b0), 4'd0, 4'd6, 4'd0, 1'b0);
    step();
    checks++;
    if (obs_v !== exp_v) begin
      failures++;
      $display("FAIL load_use_r0 got=%b exp=%b", obs_v, exp_v);
    end
  endtask

  task automatic test_reset_mid_md();
    drive(1'b0, mkctrl(1'b0, 1'b0, 1'b1), 4'd1, 4'd2, 4'd3, 1'b0);
    for (int i = 0; i < 4; i++) begin
      if (i == 2) drive(1'b1, mkctrl(1'b0, 1'b0, 1'b1), 4'd1, 4'd2, 4'd3, 1'b0);
      if (i == 3) drive(1'b0, '0, 4'd0, 4'd1, 4'd2, 1'b0);
      step();
      checks++;
      if (obs_v !== exp_v) begin
        failures++;
        $display("FAIL reset_mid_md cyc%0d got=%b exp=%b", i, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_back_to_back();
    // Load-use twice in a row, then mul/div immediately after another mul/div.
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, mkctrl(1'b0, 1'b1, 1'b0), 4'd8, 4'd8, 4'd1, 1'b0);
      step();
      checks++;
      if (obs_v !== exp_v) begin
        failures++;
        $display("FAIL b2b_load cyc%0d got=%b exp=%b", i, obs_v, exp_v);
      end
    end
    drive(1'b0, mkctrl(1'b0, 1'b0, 1'b1), 4'd2, 4'd0, 4'd0, 1'b0);
    for (int i = 0; i < 2 * (MDC - 1); i++) begin
      step();
      checks++;
      if (obs_v !== exp_v) begin
        failures++;
        $display("FAIL b2b_md cyc%0d got=%b exp=%b", i, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] pick [5];
    logic [13:0] c;
    pick[0] = 4'd0; pick[1] = 4'd1; pick[2] = 4'd2; pick[3] = 4'd3; pick[4] = 4'hF;
    for (int i = 0; i < 400; i++) begin
      c = 14'($urandom);
      if ($urandom_range(3) != 0) c[12] = 1'b0;
      drive(($urandom_range(40) == 0), c,
            pick[$urandom_range(4)], pick[$urandom_range(4)],
            pick[$urandom_range(4)], 1'($urandom));
      step();
      checks++;
      if (obs_v !== exp_v) begin
        failures++;
        $display("FAIL random cyc%0d got=%b exp=%b", i, obs_v, exp_v);
      end
    end
  endtask

  initial begin
    drive(1'b1, '0, 4'd0, 4'd1, 4'd2, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_load_use();
    test_load_branch();
    test_muldiv();
    test_no_stall();
    test_reset_mid_md();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
